// File: rtl/spmv_ctrl_regs.sv
// spmv_ctrl_regs: AXI4-Lite control/status register file for the SpMV kernel array.
// Holds CTRL/ROW_NUM/NNZ configuration, issues start and soft-reset pulses,
// and captures kernel busy/done status plus a run-cycle counter for readback.
module spmv_ctrl_regs #(
    parameter int unsigned CONF_NUM_KERNEL = 1,
    parameter int unsigned SOFT_RST_CYCLES = 16
) (
    input  logic                       axil_clk,
    input  logic                       rstn,

    input  logic                       s_axil_awvalid,
    output logic                       s_axil_awready,
    input  logic [31:0]                s_axil_awaddr,

    input  logic                       s_axil_wvalid,
    output logic                       s_axil_wready,
    input  logic [31:0]                s_axil_wdata,

    output logic                       s_axil_bvalid,
    output logic [1:0]                 s_axil_bresp,
    input  logic                       s_axil_bready,

    input  logic                       s_axil_arvalid,
    output logic                       s_axil_arready,
    input  logic [31:0]                s_axil_araddr,

    output logic                       s_axil_rvalid,
    output logic [31:0]                s_axil_rdata,
    output logic [1:0]                 s_axil_rresp,
    input  logic                       s_axil_rready,

    output logic                       ctrl_start,
    output logic                       soft_rstn,
    output logic                       ctrl_enable,
    output logic [5:0]                 ctrl_mode,
    output logic [31:0]                reg_row_num,
    output logic [31:0]                reg_nnz,

    input  logic [CONF_NUM_KERNEL-1:0] kernel_busy,
    input  logic [CONF_NUM_KERNEL-1:0] kernel_done
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned OFF_W  = 6;
    localparam int unsigned MODE_W = 6;
    localparam int unsigned SRST_W = 8;

    localparam logic [OFF_W-1:0] OFF_CTRL    = 6'h00;
    localparam logic [OFF_W-1:0] OFF_ROW_NUM = 6'h01;
    localparam logic [OFF_W-1:0] OFF_NNZ     = 6'h02;
    localparam logic [OFF_W-1:0] OFF_STATUS  = 6'h03;
    localparam logic [OFF_W-1:0] OFF_CYCLES  = 6'h04;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // write channel holding registers
    logic              aw_p_q, aw_p_d;
    logic [OFF_W-1:0]  awoff_q, awoff_d;
    logic              w_p_q, w_p_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              bvalid_q, bvalid_d;
    logic [1:0]        bresp_q, bresp_d;

    // read channel
    logic              rvalid_q, rvalid_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [1:0]        rresp_q, rresp_d;

    // configuration and control
    logic              ctrl_enable_q, ctrl_enable_d;
    logic [MODE_W-1:0] ctrl_mode_q, ctrl_mode_d;
    logic [DATA_W-1:0] row_num_q, row_num_d;
    logic [DATA_W-1:0] nnz_q, nnz_d;
    logic              ctrl_start_q, ctrl_start_d;
    logic [SRST_W-1:0] srst_cnt_q, srst_cnt_d;
    logic              soft_rstn_q, soft_rstn_d;

    // status capture
    logic [CONF_NUM_KERNEL-1:0] busy_q, busy_d;
    logic [CONF_NUM_KERNEL-1:0] done_q, done_d;
    logic [DATA_W-1:0]          cycles_q, cycles_d;

    logic              wr_commit_c;
    logic              srst_active_c;
    logic              any_busy_c;
    logic [DATA_W-1:0] status_c;
    logic [DATA_W-1:0] rd_mux_c;
    logic              rd_err_c;
    logic [OFF_W-1:0]  aroff_c;
    logic              unused_addr_bits;

    assign unused_addr_bits = ^{s_axil_awaddr[31:8], s_axil_awaddr[1:0],
                                s_axil_araddr[31:8], s_axil_araddr[1:0]};

    assign wr_commit_c   = aw_p_q & w_p_q & ~bvalid_q;
    assign srst_active_c = (srst_cnt_q != '0);
    assign any_busy_c    = |busy_q;
    assign aroff_c       = s_axil_araddr[7:2];

    // STATUS word assembly
    always_comb begin
        status_c = '0;
        status_c[0] = any_busy_c;
        status_c[1] = &done_q;
        status_c[16 +: CONF_NUM_KERNEL] = done_q;
    end

    // read data decode from current (pre-commit) register values
    always_comb begin
        rd_mux_c = '0;
        rd_err_c = 1'b0;
        case (aroff_c)
            OFF_CTRL:    rd_mux_c = {23'd0, ctrl_enable_q, 1'b0, ctrl_mode_q, 1'b0};
            OFF_ROW_NUM: rd_mux_c = row_num_q;
            OFF_NNZ:     rd_mux_c = nnz_q;
            OFF_STATUS:  rd_mux_c = status_c;
            OFF_CYCLES:  rd_mux_c = cycles_q;
            default:     rd_err_c = 1'b1;
        endcase
    end

    // next-state logic for channels, registers, pulses and status
    always_comb begin
        aw_p_d        = aw_p_q;
        awoff_d       = awoff_q;
        w_p_d         = w_p_q;
        wdata_d       = wdata_q;
        bvalid_d      = bvalid_q;
        bresp_d       = bresp_q;
        rvalid_d      = rvalid_q;
        rdata_d       = rdata_q;
        rresp_d       = rresp_q;
        ctrl_enable_d = ctrl_enable_q;
        ctrl_mode_d   = ctrl_mode_q;
        row_num_d     = row_num_q;
        nnz_d         = nnz_q;
        ctrl_start_d  = 1'b0;
        srst_cnt_d    = srst_cnt_q;
        busy_d        = busy_q;
        done_d        = done_q;
        cycles_d      = cycles_q;

        // AW/W capture is independent; commit drains both holding registers
        if (wr_commit_c) begin
            aw_p_d = 1'b0;
        end else if (s_axil_awvalid && !aw_p_q) begin
            aw_p_d  = 1'b1;
            awoff_d = s_axil_awaddr[7:2];
        end
        if (wr_commit_c) begin
            w_p_d = 1'b0;
        end else if (s_axil_wvalid && !w_p_q) begin
            w_p_d   = 1'b1;
            wdata_d = s_axil_wdata;
        end

        // soft-reset counter winds down unless reloaded below
        if (srst_active_c) begin
            srst_cnt_d = srst_cnt_q - SRST_W'(1);
        end

        if (wr_commit_c) begin
            bvalid_d = 1'b1;
            bresp_d  = RESP_OKAY;
            case (awoff_q)
                OFF_CTRL: begin
                    ctrl_mode_d   = wdata_q[6:1];
                    ctrl_enable_d = wdata_q[8];
                    if (wdata_q[7]) begin
                        srst_cnt_d = SRST_W'(SOFT_RST_CYCLES);
                    end else if (wdata_q[0] && !any_busy_c) begin
                        ctrl_start_d = 1'b1;
                    end
                end
                OFF_ROW_NUM: row_num_d = wdata_q;
                OFF_NNZ:     nnz_d     = wdata_q;
                default:     bresp_d   = RESP_SLVERR;
            endcase
        end else if (bvalid_q && s_axil_bready) begin
            bvalid_d = 1'b0;
        end

        if (s_axil_arvalid && !rvalid_q) begin
            rvalid_d = 1'b1;
            rdata_d  = rd_mux_c;
            rresp_d  = rd_err_c ? RESP_SLVERR : RESP_OKAY;
        end else if (rvalid_q && s_axil_rready) begin
            rvalid_d = 1'b0;
        end

        // status capture; soft reset and start clear take priority
        busy_d = srst_active_c ? '0 : kernel_busy;
        if (srst_active_c || ctrl_start_q) begin
            done_d = '0;
        end else begin
            done_d = done_q | kernel_done;
        end

        if (ctrl_start_q) begin
            cycles_d = '0;
        end else if (any_busy_c && (cycles_q != '1)) begin
            cycles_d = cycles_q + 32'd1;
        end
    end

    assign soft_rstn_d = (srst_cnt_d == '0);

    // state registers
    always_ff @(posedge axil_clk or negedge rstn) begin
        if (!rstn) begin
            aw_p_q        <= 1'b0;
            awoff_q       <= '0;
            w_p_q         <= 1'b0;
            wdata_q       <= '0;
            bvalid_q      <= 1'b0;
            bresp_q       <= RESP_OKAY;
            rvalid_q      <= 1'b0;
            rdata_q       <= '0;
            rresp_q       <= RESP_OKAY;
            ctrl_enable_q <= 1'b0;
            ctrl_mode_q   <= '0;
            row_num_q     <= '0;
            nnz_q         <= '0;
            ctrl_start_q  <= 1'b0;
            srst_cnt_q    <= '0;
            soft_rstn_q   <= 1'b1;
            busy_q        <= '0;
            done_q        <= '0;
            cycles_q      <= '0;
        end else begin
            aw_p_q        <= aw_p_d;
            awoff_q       <= awoff_d;
            w_p_q         <= w_p_d;
            wdata_q       <= wdata_d;
            bvalid_q      <= bvalid_d;
            bresp_q       <= bresp_d;
            rvalid_q      <= rvalid_d;
            rdata_q       <= rdata_d;
            rresp_q       <= rresp_d;
            ctrl_enable_q <= ctrl_enable_d;
            ctrl_mode_q   <= ctrl_mode_d;
            row_num_q     <= row_num_d;
            nnz_q         <= nnz_d;
            ctrl_start_q  <= ctrl_start_d;
            srst_cnt_q    <= srst_cnt_d;
            soft_rstn_q   <= soft_rstn_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            cycles_q      <= cycles_d;
        end
    end

    assign s_axil_awready = ~aw_p_q;
    assign s_axil_wready  = ~w_p_q;
    assign s_axil_bvalid  = bvalid_q;
    assign s_axil_bresp   = bresp_q;
    assign s_axil_arready = ~rvalid_q;
    assign s_axil_rvalid  = rvalid_q;
    assign s_axil_rdata   = rdata_q;
    assign s_axil_rresp   = rresp_q;
    assign ctrl_start     = ctrl_start_q;
    assign soft_rstn      = soft_rstn_q;
    assign ctrl_enable    = ctrl_enable_q;
    assign ctrl_mode      = ctrl_mode_q;
    assign reg_row_num    = row_num_q;
    assign reg_nnz        = nnz_q;

endmodule

// File: tb/tb_spmv_ctrl_regs.sv
// Directed testbench for spmv_ctrl_regs.
module tb_spmv_ctrl_regs;

    localparam int unsigned NK = 1;

    logic          axil_clk;
    logic          rstn;
    logic          s_axil_awvalid, s_axil_awready;
    logic [31:0]   s_axil_awaddr;
    logic          s_axil_wvalid, s_axil_wready;
    logic [31:0]   s_axil_wdata;
    logic          s_axil_bvalid;
    logic [1:0]    s_axil_bresp;
    logic          s_axil_bready;
    logic          s_axil_arvalid, s_axil_arready;
    logic [31:0]   s_axil_araddr;
    logic          s_axil_rvalid;
    logic [31:0]   s_axil_rdata;
    logic [1:0]    s_axil_rresp;
    logic          s_axil_rready;
    logic          ctrl_start, soft_rstn, ctrl_enable;
    logic [5:0]    ctrl_mode;
    logic [31:0]   reg_row_num, reg_nnz;
    logic [NK-1:0] kernel_busy, kernel_done;

    int tests = 0;
    int fails = 0;
    int start_cnt = 0;
    int srst_low_cnt = 0;

    spmv_ctrl_regs #(.CONF_NUM_KERNEL(NK), .SOFT_RST_CYCLES(16)) dut (
        .axil_clk(axil_clk), .rstn(rstn),
        .s_axil_awvalid(s_axil_awvalid), .s_axil_awready(s_axil_awready), .s_axil_awaddr(s_axil_awaddr),
        .s_axil_wvalid(s_axil_wvalid), .s_axil_wready(s_axil_wready), .s_axil_wdata(s_axil_wdata),
        .s_axil_bvalid(s_axil_bvalid), .s_axil_bresp(s_axil_bresp), .s_axil_bready(s_axil_bready),
        .s_axil_arvalid(s_axil_arvalid), .s_axil_arready(s_axil_arready), .s_axil_araddr(s_axil_araddr),
        .s_axil_rvalid(s_axil_rvalid), .s_axil_rdata(s_axil_rdata), .s_axil_rresp(s_axil_rresp),
        .s_axil_rready(s_axil_rready),
        .ctrl_start(ctrl_start), .soft_rstn(soft_rstn), .ctrl_enable(ctrl_enable), .ctrl_mode(ctrl_mode),
        .reg_row_num(reg_row_num), .reg_nnz(reg_nnz),
        .kernel_busy(kernel_busy), .kernel_done(kernel_done)
    );

    initial axil_clk = 1'b0;
    always #5 axil_clk = ~axil_clk;

    // count cycles with ctrl_start high and with soft_rstn low
    always @(posedge axil_clk) begin
        if (ctrl_start) start_cnt <= start_cnt + 1;
        if (!soft_rstn) srst_low_cnt <= srst_low_cnt + 1;
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge axil_clk);
        #1;
    endtask

    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, output logic [1:0] resp);
        int n;
        bit aw_acc, w_acc;
        s_axil_awaddr = addr; s_axil_wdata = data;
        s_axil_awvalid = 1'b1; s_axil_wvalid = 1'b1;
        n = 0;
        while ((s_axil_awvalid || s_axil_wvalid) && n < 50) begin
            aw_acc = s_axil_awvalid && s_axil_awready;
            w_acc  = s_axil_wvalid && s_axil_wready;
            @(posedge axil_clk); #1;
            if (aw_acc) s_axil_awvalid = 1'b0;
            if (w_acc)  s_axil_wvalid  = 1'b0;
            n++;
        end
        n = 0;
        while (!s_axil_bvalid && n < 50) begin
            @(posedge axil_clk); #1;
            n++;
        end
        resp = s_axil_bresp;
        tests++;
        if (!s_axil_bvalid) begin
            fails++;
            $display("FAIL write_timeout addr=%h: no bvalid within bound", addr);
            s_axil_awvalid = 1'b0; s_axil_wvalid = 1'b0;
        end else begin
            @(posedge axil_clk); #1;
        end
    endtask

    task automatic axi_read(input logic [31:0] addr, output logic [31:0] data, output logic [1:0] resp);
        int n;
        s_axil_araddr = addr; s_axil_arvalid = 1'b1;
        n = 0;
        while (!s_axil_arready && n < 50) begin
            @(posedge axil_clk); #1;
            n++;
        end
        @(posedge axil_clk); #1;
        s_axil_arvalid = 1'b0;
        n = 0;
        while (!s_axil_rvalid && n < 50) begin
            @(posedge axil_clk); #1;
            n++;
        end
        data = s_axil_rdata; resp = s_axil_rresp;
        tests++;
        if (!s_axil_rvalid) begin
            fails++;
            $display("FAIL read_timeout addr=%h: no rvalid within bound", addr);
        end else begin
            @(posedge axil_clk); #1;
        end
    endtask

    task automatic test_reset;
        logic [31:0] d;
        logic [1:0]  r;
        tests++;
        if ({s_axil_awready, s_axil_wready, s_axil_arready, s_axil_bvalid, s_axil_rvalid} !== 5'b11100) begin
            fails++; $display("FAIL reset_handshake got=%b exp=11100",
                {s_axil_awready, s_axil_wready, s_axil_arready, s_axil_bvalid, s_axil_rvalid});
        end
        tests++;
        if ({s_axil_bresp, s_axil_rresp, s_axil_rdata} !== 36'd0) begin
            fails++; $display("FAIL reset_resp got bresp=%b rresp=%b rdata=%h exp 0", s_axil_bresp, s_axil_rresp, s_axil_rdata);
        end
        tests++;
        if ({ctrl_start, soft_rstn, ctrl_enable, ctrl_mode} !== 9'b010000000) begin
            fails++; $display("FAIL reset_ctrl got start=%b srstn=%b en=%b mode=%h exp 0,1,0,0",
                ctrl_start, soft_rstn, ctrl_enable, ctrl_mode);
        end
        tests++;
        if ({reg_row_num, reg_nnz} !== 64'd0) begin
            fails++; $display("FAIL reset_regs got row=%h nnz=%h exp 0", reg_row_num, reg_nnz);
        end
        axi_read(32'h10, d, r);
        tests++;
        if (d !== 32'd0) begin fails++; $display("FAIL reset_cycles got=%h exp=0", d); end
        axi_read(32'h0C, d, r);
        tests++;
        if (d !== 32'd0) begin fails++; $display("FAIL reset_status got=%h exp=0", d); end
    endtask

    task automatic test_write_latency;
        logic [31:0] d;
        logic [1:0]  r;
        // AW one cycle before W
        s_axil_awaddr = 32'h04; s_axil_awvalid = 1'b1;
        @(posedge axil_clk); #1;
        s_axil_awvalid = 1'b0;
        s_axil_wdata = 32'h80; s_axil_wvalid = 1'b1;
        tests++;
        if ({s_axil_awready, s_axil_wready, s_axil_bvalid} !== 3'b010) begin
            fails++; $display("FAIL wr_after_aw got awr/wr/bv=%b exp=010", {s_axil_awready, s_axil_wready, s_axil_bvalid});
        end
        @(posedge axil_clk); #1;
        s_axil_wvalid = 1'b0;
        tests++;
        if ({s_axil_awready, s_axil_wready, s_axil_bvalid} !== 3'b000 || reg_row_num !== 32'd0) begin
            fails++; $display("FAIL wr_after_w got awr/wr/bv=%b row=%h exp=000 row=0",
                {s_axil_awready, s_axil_wready, s_axil_bvalid}, reg_row_num);
        end
        @(posedge axil_clk); #1;
        tests++;
        if ({s_axil_awready, s_axil_wready, s_axil_bvalid} !== 3'b111 || s_axil_bresp !== 2'b00 || reg_row_num !== 32'h80) begin
            fails++; $display("FAIL wr_commit got awr/wr/bv=%b bresp=%b row=%h exp=111 00 80",
                {s_axil_awready, s_axil_wready, s_axil_bvalid}, s_axil_bresp, reg_row_num);
        end
        @(posedge axil_clk); #1;
        tests++;
        if (s_axil_bvalid !== 1'b0) begin fails++; $display("FAIL wr_bclear got bvalid=%b exp=0", s_axil_bvalid); end
        // AW and W together: commit one edge later
        s_axil_awaddr = 32'h08; s_axil_wdata = 32'h1234_5678;
        s_axil_awvalid = 1'b1; s_axil_wvalid = 1'b1;
        @(posedge axil_clk); #1;
        s_axil_awvalid = 1'b0; s_axil_wvalid = 1'b0;
        tests++;
        if (s_axil_bvalid !== 1'b0 || reg_nnz !== 32'd0) begin
            fails++; $display("FAIL wr_same_pre got bvalid=%b nnz=%h exp=0 0", s_axil_bvalid, reg_nnz);
        end
        @(posedge axil_clk); #1;
        tests++;
        if (s_axil_bvalid !== 1'b1 || reg_nnz !== 32'h1234_5678) begin
            fails++; $display("FAIL wr_same_commit got bvalid=%b nnz=%h exp=1 12345678", s_axil_bvalid, reg_nnz);
        end
        cycles(1);
        // read latency: rvalid one edge after AR acceptance
        s_axil_araddr = 32'h04; s_axil_arvalid = 1'b1;
        @(posedge axil_clk); #1;
        s_axil_arvalid = 1'b0;
        tests++;
        if (s_axil_rvalid !== 1'b1 || s_axil_rdata !== 32'h80 || s_axil_rresp !== 2'b00 || s_axil_arready !== 1'b0) begin
            fails++; $display("FAIL rd_row got rvalid=%b rdata=%h rresp=%b arready=%b exp=1 80 00 0",
                s_axil_rvalid, s_axil_rdata, s_axil_rresp, s_axil_arready);
        end
        @(posedge axil_clk); #1;
        tests++;
        if (s_axil_rvalid !== 1'b0) begin fails++; $display("FAIL rd_rclear got rvalid=%b exp=0", s_axil_rvalid); end
        axi_read(32'h08, d, r);
        tests++;
        if (d !== 32'h1234_5678 || r !== 2'b00) begin fails++; $display("FAIL rd_nnz got=%h/%b exp=12345678/00", d, r); end
    endtask

    task automatic test_start;
        logic [31:0] d;
        logic [1:0]  r;
        int s0;
        kernel_busy = '0;
        s0 = start_cnt;
        axi_write(32'h00, 32'h12B, r);
        cycles(3);
        tests++;
        if (start_cnt - s0 !== 1) begin fails++; $display("FAIL start_pulse got=%0d cycles exp=1", start_cnt - s0); end
        tests++;
        if (ctrl_enable !== 1'b1 || ctrl_mode !== 6'h15 || r !== 2'b00) begin
            fails++; $display("FAIL start_levels got en=%b mode=%h bresp=%b exp=1 15 00", ctrl_enable, ctrl_mode, r);
        end
        axi_read(32'h00, d, r);
        tests++;
        if (d !== 32'h12A) begin fails++; $display("FAIL ctrl_readback got=%h exp=12a", d); end
    endtask

    task automatic test_soft_reset;
        logic [31:0] d;
        logic [1:0]  r;
        int s0, l0;
        kernel_done = '1;
        cycles(1);
        kernel_done = '0;
        cycles(1);
        axi_read(32'h0C, d, r);
        tests++;
        if (d !== 32'h0001_0002) begin fails++; $display("FAIL srst_pre_status got=%h exp=00010002", d); end
        s0 = start_cnt; l0 = srst_low_cnt;
        axi_write(32'h00, 32'h1AA, r);
        tests++;
        if (soft_rstn !== 1'b0) begin fails++; $display("FAIL srst_low got soft_rstn=%b exp=0", soft_rstn); end
        axi_read(32'h0C, d, r);
        tests++;
        if (d !== 32'd0) begin fails++; $display("FAIL srst_done_clr got=%h exp=0", d); end
        cycles(20);
        tests++;
        if (srst_low_cnt - l0 !== 16 || start_cnt - s0 !== 0 || soft_rstn !== 1'b1) begin
            fails++; $display("FAIL srst_len got low=%0d starts=%0d srstn=%b exp=16 0 1",
                srst_low_cnt - l0, start_cnt - s0, soft_rstn);
        end
        // start in the same write as soft reset is suppressed
        s0 = start_cnt; l0 = srst_low_cnt;
        axi_write(32'h00, 32'h1AB, r);
        cycles(20);
        tests++;
        if (srst_low_cnt - l0 !== 16 || start_cnt - s0 !== 0) begin
            fails++; $display("FAIL srst_suppress got low=%0d starts=%0d exp=16 0", srst_low_cnt - l0, start_cnt - s0);
        end
        s0 = start_cnt;
        axi_write(32'h00, 32'h12B, r);
        cycles(3);
        tests++;
        if (start_cnt - s0 !== 1) begin fails++; $display("FAIL srst_then_start got=%0d exp=1", start_cnt - s0); end
    endtask

    task automatic test_busy_cycles;
        logic [31:0] d;
        logic [1:0]  r;
        int s0;
        axi_write(32'h00, 32'h101, r);
        cycles(2);
        kernel_busy = '1;
        cycles(100);
        kernel_busy = '0;
        cycles(2);
        kernel_done = '1;
        cycles(1);
        kernel_done = '0;
        cycles(1);
        axi_read(32'h10, d, r);
        tests++;
        if (d !== 32'd100) begin fails++; $display("FAIL cycles_count got=%0d exp=100", d); end
        axi_read(32'h0C, d, r);
        tests++;
        if (d !== 32'h0001_0002) begin fails++; $display("FAIL status_done got=%h exp=00010002", d); end
        // start while busy is ignored
        kernel_busy = '1;
        cycles(2);
        s0 = start_cnt;
        axi_write(32'h00, 32'h101, r);
        cycles(3);
        axi_read(32'h0C, d, r);
        tests++;
        if (start_cnt - s0 !== 0 || d !== 32'h0001_0003) begin
            fails++; $display("FAIL start_busy got starts=%0d status=%h exp=0 00010003", start_cnt - s0, d);
        end
        kernel_busy = '0;
        cycles(2);
        // start while idle clears done and CYCLES
        axi_write(32'h00, 32'h101, r);
        cycles(2);
        axi_read(32'h0C, d, r);
        tests++;
        if (d !== 32'd0) begin fails++; $display("FAIL start_clr_status got=%h exp=0", d); end
        axi_read(32'h10, d, r);
        tests++;
        if (d !== 32'd0) begin fails++; $display("FAIL start_clr_cycles got=%0d exp=0", d); end
    endtask

    task automatic test_slverr;
        logic [31:0] d, st0;
        logic [1:0]  r;
        kernel_done = '1;
        cycles(1);
        kernel_done = '0;
        axi_read(32'h0C, st0, r);
        axi_write(32'h0C, 32'hFFFF_FFFF, r);
        tests++;
        if (r !== 2'b10) begin fails++; $display("FAIL wr_status_resp got=%b exp=10", r); end
        axi_write(32'h10, 32'hFFFF_FFFF, r);
        tests++;
        if (r !== 2'b10) begin fails++; $display("FAIL wr_cycles_resp got=%b exp=10", r); end
        axi_write(32'h40, 32'h5555_5555, r);
        tests++;
        if (r !== 2'b10 || reg_row_num !== 32'h80 || reg_nnz !== 32'h1234_5678) begin
            fails++; $display("FAIL wr_unmapped got resp=%b row=%h nnz=%h exp=10 80 12345678", r, reg_row_num, reg_nnz);
        end
        axi_read(32'h0C, d, r);
        tests++;
        if (d !== st0 || d !== 32'h0001_0002) begin fails++; $display("FAIL status_unchanged got=%h exp=00010002", d); end
        axi_read(32'h40, d, r);
        tests++;
        if (r !== 2'b10 || d !== 32'd0) begin fails++; $display("FAIL rd_unmapped got=%h/%b exp=0/10", d, r); end
        axi_read(32'h104, d, r);
        tests++;
        if (r !== 2'b00 || d !== 32'h80) begin fails++; $display("FAIL rd_upper_ignored got=%h/%b exp=80/00", d, r); end
    endtask

    task automatic test_back_to_back;
        int n;
        bit aw_acc, w_acc;
        s_axil_bready = 1'b0;
        // first write
        s_axil_awaddr = 32'h04; s_axil_wdata = 32'h11;
        s_axil_awvalid = 1'b1; s_axil_wvalid = 1'b1;
        @(posedge axil_clk); #1;
        // second write offered immediately
        s_axil_awaddr = 32'h08; s_axil_wdata = 32'h22;
        n = 0;
        while ((s_axil_awvalid || s_axil_wvalid) && n < 50) begin
            aw_acc = s_axil_awvalid && s_axil_awready;
            w_acc  = s_axil_wvalid && s_axil_wready;
            @(posedge axil_clk); #1;
            if (aw_acc) s_axil_awvalid = 1'b0;
            if (w_acc)  s_axil_wvalid  = 1'b0;
            n++;
        end
        cycles(5);
        tests++;
        if (s_axil_bvalid !== 1'b1 || s_axil_bresp !== 2'b00 || reg_row_num !== 32'h11 ||
            reg_nnz !== 32'h1234_5678 || s_axil_awready !== 1'b0) begin
            fails++; $display("FAIL b2b_hold got bv=%b bresp=%b row=%h nnz=%h awr=%b exp=1 00 11 12345678 0",
                s_axil_bvalid, s_axil_bresp, reg_row_num, reg_nnz, s_axil_awready);
        end
        s_axil_bready = 1'b1;
        @(posedge axil_clk); #1;
        s_axil_bready = 1'b0;
        tests++;
        if (s_axil_bvalid !== 1'b0 || reg_nnz !== 32'h1234_5678) begin
            fails++; $display("FAIL b2b_first_b got bv=%b nnz=%h exp=0 12345678", s_axil_bvalid, reg_nnz);
        end
        @(posedge axil_clk); #1;
        tests++;
        if (s_axil_bvalid !== 1'b1 || s_axil_bresp !== 2'b00 || reg_nnz !== 32'h22 || reg_row_num !== 32'h11) begin
            fails++; $display("FAIL b2b_second got bv=%b bresp=%b nnz=%h row=%h exp=1 00 22 11",
                s_axil_bvalid, s_axil_bresp, reg_nnz, reg_row_num);
        end
        s_axil_bready = 1'b1;
        cycles(2);
        tests++;
        if (s_axil_bvalid !== 1'b0) begin fails++; $display("FAIL b2b_drain got bv=%b exp=0", s_axil_bvalid); end
    endtask

    task automatic test_reset_mid;
        s_axil_awaddr = 32'h04; s_axil_wdata = 32'hDEAD_BEEF;
        s_axil_awvalid = 1'b1; s_axil_wvalid = 1'b1;
        @(posedge axil_clk); #1;
        s_axil_awvalid = 1'b0; s_axil_wvalid = 1'b0;
        rstn = 1'b0;
        #2;
        rstn = 1'b1;
        cycles(2);
        tests++;
        if (s_axil_bvalid !== 1'b0 || reg_row_num !== 32'd0 || s_axil_awready !== 1'b1 || s_axil_wready !== 1'b1) begin
            fails++; $display("FAIL reset_mid got bv=%b row=%h awr=%b wr=%b exp=0 0 1 1",
                s_axil_bvalid, reg_row_num, s_axil_awready, s_axil_wready);
        end
    endtask

    initial begin
        rstn = 1'b0;
        s_axil_awvalid = 1'b0; s_axil_awaddr = '0;
        s_axil_wvalid = 1'b0;  s_axil_wdata = '0;
        s_axil_bready = 1'b1;
        s_axil_arvalid = 1'b0; s_axil_araddr = '0;
        s_axil_rready = 1'b1;
        kernel_busy = '0; kernel_done = '0;
        repeat (3) @(posedge axil_clk);
        #1 rstn = 1'b1;
        cycles(1);
        test_reset();
        test_write_latency();
        test_start();
        test_soft_reset();
        test_busy_cycles();
        test_slverr();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
